// File: rtl/obstacle_spawner.sv
// ============================================================================
// Module   : obstacle_spawner
// Purpose  : Spawns one obstacle at a time in a pseudo-random lane. It scrolls
//            the obstacle down the track at a programmable speed, retires it
//            at the bottom, waits a gap, and then spawns the next one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obstacle_spawner #(
    parameter int          HWIDTH      = 12,
    parameter int          VWIDTH      = 12,
    parameter int          LWIDTH      = 2,
    parameter int          NUM_LANES   = 3,
    parameter int          OBST_LANE   = 1,
    parameter int          COUNT_WIDTH = 32,
    parameter int          TICK_DIV    = 4,
    parameter int          GAP_TICKS   = 2,
    parameter int          SPAWN_V     = -16,
    parameter int          DESPAWN_V   = 64,
    parameter int          LANE_X0     = 100,
    parameter int          LANE_PITCH  = 80,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic                                 restart,
    input  logic [3:0]                           speed,
    output logic [HWIDTH-1:0]                    obst_hoffset,
    output logic [VWIDTH-1:0]                    obst_voffset,
    output logic [OBST_LANE-1:0][LWIDTH-1:0]     obst_lane,
    output logic                                 obst_valid,
    output logic [COUNT_WIDTH-1:0]               passed_count
);

    localparam int          DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          GAP_W     = $clog2(GAP_TICKS + 1);
    localparam int          NUM_BASES = NUM_LANES - OBST_LANE + 1;
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam logic signed [VWIDTH:0] DESPAWN_X = (VWIDTH+1)'(DESPAWN_V);

    // Elaboration-time parameter sanity checks
    if (DESPAWN_V + 15 > (2 ** (VWIDTH - 1)) - 1) begin : g_chk_despawn
        $error("DESPAWN_V+15 does not fit in signed VWIDTH");
    end
    if (OBST_LANE > NUM_LANES) begin : g_chk_lanes
        $error("OBST_LANE must not exceed NUM_LANES");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GAP   = 2'd1,
        S_SPAWN = 2'd2,
        S_MOVE  = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [DIV_W-1:0]                   div_q, div_d;
    logic [GAP_W-1:0]                   gap_q, gap_d;
    logic [15:0]                        lfsr_q, lfsr_d;
    logic [HWIDTH-1:0]                  hoff_q, hoff_d;
    logic [VWIDTH-1:0]                  voff_q, voff_d;
    logic [OBST_LANE-1:0][LWIDTH-1:0]   lane_q, lane_d, lane_init;
    logic                               valid_q, valid_d;
    logic [COUNT_WIDTH-1:0]             count_q, count_d;

    logic                               tick;
    logic [7:0]                         base;
    logic signed [VWIDTH:0]             next_v;

    // Galois LFSR (x^16+x^14+x^13+x^11+1) advances every clock, paused or not
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // Lane indices after reset/restart are simply 0..OBST_LANE-1
    always_comb begin
        lane_init = '0;
        for (int i = 0; i < OBST_LANE; i++) begin
            lane_init[i] = LWIDTH'(i);
        end
    end

    assign tick   = enable && (div_q == DIV_W'(TICK_DIV - 1));
    assign base   = lfsr_q[7:0] % 8'(NUM_BASES);
    assign next_v = {voff_q[VWIDTH-1], voff_q} + {{(VWIDTH-3){1'b0}}, speed};

    // Next-state logic: restart overrides everything, otherwise enable gates progress
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        hoff_d  = hoff_q;
        voff_d  = voff_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        count_d = count_q;

        if (restart) begin
            state_d = S_IDLE;
            div_d   = '0;
            gap_d   = '0;
            hoff_d  = HWIDTH'(LANE_X0);
            voff_d  = VWIDTH'(SPAWN_V);
            lane_d  = lane_init;
            valid_d = 1'b0;
            count_d = '0;
        end else begin
            if (enable) begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        gap_d = gap_q + GAP_W'(1);
                        if (gap_d == GAP_W'(GAP_TICKS)) begin
                            state_d = S_SPAWN;
                        end
                    end
                end
                // Spawn completes in one cycle even if enable has dropped
                S_SPAWN: begin
                    for (int i = 0; i < OBST_LANE; i++) begin
                        lane_d[i] = LWIDTH'(base) + LWIDTH'(i);
                    end
                    hoff_d  = HWIDTH'(LANE_X0 + int'(base) * LANE_PITCH);
                    voff_d  = VWIDTH'(SPAWN_V);
                    valid_d = 1'b1;
                    state_d = S_MOVE;
                end
                S_MOVE: begin
                    if (tick) begin
                        if (next_v >= DESPAWN_X) begin
                            valid_d = 1'b0;
                            voff_d  = VWIDTH'(SPAWN_V);
                            count_d = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);
                            gap_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            voff_d = next_v[VWIDTH-1:0];
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            lfsr_q  <= SEED;
            hoff_q  <= HWIDTH'(LANE_X0);
            voff_q  <= VWIDTH'(SPAWN_V);
            lane_q  <= lane_init;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
            hoff_q  <= hoff_d;
            voff_q  <= voff_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign obst_hoffset = hoff_q;
    assign obst_voffset = voff_q;
    assign obst_lane    = lane_q;
    assign obst_valid   = valid_q;
    assign passed_count = count_q;

endmodule

`default_nettype wire
